// File: rtl/input_sync_filter.sv
// Input conditioning for pad-driven control inputs: synchroniser, glitch filter,
// registered edge pulses and a saturating rising-edge event counter.
module input_sync_filter #(
   parameter int SYNC_STAGES   = 2,
   parameter int FILTER_CYCLES = 4,
   parameter int CNT_WIDTH     = 16
) (
   input  logic                 IQC,
   input  logic                 QRT,
   input  logic                 IQZ,
   input  logic                 EN,
   input  logic                 CNT_CLR,
   output logic                 FILT,
   output logic                 RISE,
   output logic                 FALL,
   output logic [CNT_WIDTH-1:0] EVT_CNT,
   output logic                 OVF
);

   localparam logic [7:0] CNT_LAST = 8'(FILTER_CYCLES - 1);

   logic [SYNC_STAGES-1:0] s;
   logic [7:0]             cnt;
   logic                   sync_out;
   logic                   qualify;
   logic                   rise_evt;
   logic                   cnt_full;

   // s[0] may go metastable; only s[1] ever samples it.
   always_ff @(posedge IQC) begin
      if (QRT) begin
         s <= '0;
      end else begin
         s <= {s[SYNC_STAGES-2:0], IQZ};
      end
   end

   assign sync_out = s[SYNC_STAGES-1];

   always_comb begin
      qualify  = EN && (sync_out != FILT) && (cnt == CNT_LAST);
      rise_evt = qualify && sync_out;
      cnt_full = &EVT_CNT;
   end

   always_ff @(posedge IQC) begin
      if (QRT) begin
         cnt  <= '0;
         FILT <= 1'b0;
         RISE <= 1'b0;
         FALL <= 1'b0;
      end else begin
         RISE <= 1'b0;
         FALL <= 1'b0;
         if (!EN) begin
            cnt <= '0;
         end else if (sync_out == FILT) begin
            cnt <= '0;
         end else if (qualify) begin
            FILT <= sync_out;
            cnt  <= '0;
            RISE <= sync_out;
            FALL <= !sync_out;
         end else begin
            cnt <= cnt + 8'd1;
         end
      end
   end

   // A clear coinciding with a rise keeps that rise as the first new event.
   always_ff @(posedge IQC) begin
      if (QRT) begin
         EVT_CNT <= '0;
         OVF     <= 1'b0;
      end else if (CNT_CLR) begin
         EVT_CNT <= rise_evt ? CNT_WIDTH'(1) : '0;
         OVF     <= 1'b0;
      end else if (rise_evt) begin
         if (cnt_full) begin
            OVF <= 1'b1;
         end else begin
            EVT_CNT <= EVT_CNT + CNT_WIDTH'(1);
         end
      end
   end

endmodule

// File: doc/input_sync_filter.md
Name: input_sync_filter

Overview:
- Fabric-side stage directly downstream of the input IO cell.
- Consumes the cell's IQZ output, which is asynchronous to the fabric clock when the cell is in buffer mode.
- Synchronises IQZ into the IQC domain, rejects glitches shorter than a programmable number of cycles, and emits a clean level, one-cycle edge pulses and a saturating rising-edge event counter.
- Used for pad-driven control inputs such as buttons, strobes and external interrupts.

Parameters:
- SYNC_STAGES, 2: depth of the synchroniser flop chain; legal range 2..4.
- FILTER_CYCLES, 4: consecutive stable cycles required before FILT changes; legal range 1..255.
- CNT_WIDTH, 16: width of EVT_CNT; legal range 2..32.

Ports:
- IQC  input  1  clock, shared with the IO cell's register clock.
- QRT  input  1  reset; synchronous, active-high.
- IQZ  input  1  raw pad level from the input IO cell; asynchronous.
- EN  input  1  filter enable.
- CNT_CLR  input  1  synchronous clear of EVT_CNT and OVF.
- FILT  output  1  filtered, synchronised level.
- RISE  output  1  one-cycle pulse on FILT 0->1.
- FALL  output  1  one-cycle pulse on FILT 1->0.
- EVT_CNT  output  CNT_WIDTH  count of FILT rising edges; saturating.
- OVF  output  1  sticky flag: a rise occurred while EVT_CNT was all-ones.

Behaviour:
- Interface: one clock, IQC; reset QRT is synchronous and active-high.
- QRT priority: QRT=1 at a rising IQC edge overrides every other input. It forces the sync chain, filter counter, FILT, RISE, FALL, EVT_CNT and OVF to 0.
- Sync chain: s[0]<=IQZ, s[i]<=s[i-1]. The chain runs regardless of EN. sync_out = s[SYNC_STAGES-1].
- Filter: 8-bit counter cnt, reset 0. Each edge with EN=1:
  - sync_out==FILT: cnt<=0.
  - else if cnt==FILTER_CYCLES-1: FILT<=sync_out, cnt<=0.
  - else: cnt<=cnt+1.
- Glitch rejection: a sync_out excursion shorter than FILTER_CYCLES cycles leaves FILT unchanged and returns cnt to 0.
- EN=0: cnt forced to 0; FILT, RISE/FALL logic and the counter hold; no edges are generated. Re-enabling restarts qualification from cnt=0.
- Latency: IQZ settled before edge 0 gives FILT updated at edge SYNC_STAGES+FILTER_CYCLES-1. With defaults, FILT is visible after the 6th edge.
- FILTER_CYCLES=1: FILT follows sync_out with one edge of delay.
- RISE/FALL: registered. Asserted for exactly the one cycle in which FILT holds its new value, i.e. set on the same edge that updates FILT and cleared on the next edge. Never both high.
- EVT_CNT: increments on the edge at which RISE is set.
  - At all-ones it holds (saturates) and OVF is set.
  - OVF stays set until CNT_CLR or QRT.
- CNT_CLR=1 without a rise: EVT_CNT<=0, OVF<=0.
- CNT_CLR=1 on the same edge as a rise: EVT_CNT<=1, OVF<=0. The event is not lost.
- CNT_CLR does not affect the sync chain, filter or FILT.
- QRT mid-qualification: pending count discarded. After reset release FILT=0; a high IQZ then requalifies with full latency and produces a RISE.
- Metastability is confined to s[0]. No logic other than s[1] reads s[0].

Test Plan:
- Reset: hold IQZ=1, QRT=1 for 3 cycles -> all outputs 0. Release QRT -> FILT=1 and RISE=1 after exactly 6 edges, EVT_CNT=1.
- Clean edges with defaults: IQZ 0->1, then 1->0 after 20 cycles -> one RISE pulse and one FALL pulse, each 1 cycle wide, each 6 edges after its IQZ change; EVT_CNT=1.
- Glitches: IQZ high for 3 cycles, then low -> FILT, RISE and EVT_CNT unchanged. High for 4 cycles -> FILT rises.
- EN gating: EN=0 while IQZ toggles for 30 cycles -> no FILT change. Set EN=1 with IQZ held high -> RISE 4 edges later (sync already settled).
- Saturation with CNT_WIDTH=4: 15 qualified rises -> EVT_CNT=15, OVF=0. 16th rise -> EVT_CNT=15, OVF=1. CNT_CLR -> 0/0.
- Clear coincidence: CNT_CLR asserted on the edge RISE is set, with EVT_CNT=7 -> EVT_CNT=1, OVF=0.
